// File: rtl/k_wput_rr_arb_t1.sv
// Round-robin arbiter that shares the single write port of the 2-deep MCP FIFO.
// Each grant latches the winner's word and produces one wput pulse and one ack.
module k_wput_rr_arb_t1 #(
  parameter int data_size = 8,
  parameter int num_req   = 4,
  parameter int id_size   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arb_en,
  input  logic [num_req-1:0]           req,
  input  logic [num_req*data_size-1:0] req_data,
  input  logic                         wrdy,
  output logic                         wput,
  output logic [data_size-1:0]         wdata,
  output logic [num_req-1:0]           ack,
  output logic [id_size-1:0]           gnt_id,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, PUT, HOLD} state_t;

  state_t                state_q, state_d;
  logic [id_size-1:0]    last_q, last_d;
  logic [id_size-1:0]    gnt_d;
  logic [data_size-1:0]  wdata_d;
  logic [num_req-1:0]    ack_d;
  logic                  wput_d, busy_d;

  // Rotating scan: first requester after the last one served wins.
  logic                  found;
  logic [id_size-1:0]    win;
  int                    cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int i = 1; i <= num_req; i++) begin
      cand = int'(last_q) + i;
      if (cand >= num_req) cand = cand - num_req;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = id_size'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_id;
    wdata_d = wdata;
    wput_d  = 1'b0;
    ack_d   = '0;
    case (state_q)
      IDLE: if (arb_en && wrdy && found) begin
        state_d = PUT;
        wput_d  = 1'b1;
        ack_d   = num_req'(1) << win;
        wdata_d = req_data[int'(win)*data_size +: data_size];
        gnt_d   = win;
      end
      PUT: begin
        last_d  = gnt_id;
        state_d = HOLD;
      end
      // wrdy still reflects the previous put here, so it is not looked at.
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= id_size'(num_req - 1);
      gnt_id  <= '0;
      wdata   <= '0;
      wput    <= 1'b0;
      ack     <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_id  <= gnt_d;
      wdata   <= wdata_d;
      wput    <= wput_d;
      ack     <= ack_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_k_wput_rr_arb_t1.sv
// Randomized and directed bench for k_wput_rr_arb_t1 against an edge-counting
// transaction model: a grant may start once three edges have passed since the last one.
module tb_k_wput_rr_arb_t1;
  localparam int DW = 8, NR = 4, IW = 2;

  logic              clk = 1'b0, rst_n = 1'b0, arb_en = 1'b0, wrdy = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic              wput, busy;
  logic [DW-1:0]     wdata;
  logic [NR-1:0]     ack;
  logic [IW-1:0]     gnt_id;

  k_wput_rr_arb_t1 #(.data_size(DW), .num_req(NR), .id_size(IW)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .req_data(req_data),
    .wrdy(wrdy), .wput(wput), .wdata(wdata), .ack(ack), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int edge_k, free_at, m_last, m_gnt, n_wput = 0, n_ack = 0;
  logic m_wput, m_busy;
  logic [NR-1:0] m_ack;
  logic [DW-1:0] m_wdata;
  int gnt_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    edge_k = 0; free_at = 0; m_last = NR - 1; m_gnt = 0;
    m_wput = 1'b0; m_ack = '0; m_wdata = '0; m_busy = 1'b0;
  endtask

  function automatic logic [NR*DW-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  // Drive one cycle of inputs, predict the outputs after the next edge, check them.
  task automatic step(input logic en, input logic [NR-1:0] r, input logic w,
                      input logic [NR*DW-1:0] d);
    int c;
    arb_en = en; req = r; wrdy = w; req_data = d;
    m_wput = 1'b0; m_ack = '0;
    if (edge_k >= free_at && en && w && r != '0) begin
      for (int i = 1; i <= NR; i++) begin
        c = (m_last + i) % NR;
        if (r[c]) begin m_gnt = c; break; end
      end
      m_wput  = 1'b1;
      m_ack   = NR'(1) << m_gnt;
      m_wdata = d[m_gnt*DW +: DW];
      m_last  = m_gnt;
      free_at = edge_k + 3;
    end
    m_busy = (edge_k + 2 <= free_at);
    edge_k++;
    @(negedge clk);
    chk("wput", wput, m_wput);
    chk("ack", ack, m_ack);
    chk("wdata", wdata, m_wdata);
    chk("gnt_id", gnt_id, m_gnt);
    chk("busy", busy, m_busy);
    if (wput) begin n_wput++; gnt_log.push_back(int'(gnt_id)); end
    if (ack != '0) n_ack++;
  endtask

  initial begin
    logic [NR*DW-1:0] d;
    int start, exp_id, c0, hold;

    // Reset with everything asserted: outputs must stay quiet.
    model_reset();
    arb_en = 1'b1; req = '1; wrdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_wput", wput, 0);
      chk("rst_ack", ack, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_busy", busy, 0);
    end
    rst_n = 1'b1;

    // Single requester 2 with word A5.
    d = rnd_data(); d[23:16] = 8'hA5;
    step(1'b1, 4'b0100, 1'b1, d);
    chk("t2_wdata", wdata, 8'hA5);
    chk("t2_gnt", gnt_id, 2);
    chk("t2_ack", ack, 4'b0100);
    step(1'b1, 4'b0000, 1'b1, rnd_data());
    chk("t2_drop", wput, 0);
    repeat (2) step(1'b1, 4'b0000, 1'b1, rnd_data());

    // Fairness with a FIFO that drops wrdy for two cycles after each put.
    start = (m_last + 1) % NR;
    gnt_log.delete();
    hold = 0;
    repeat (40) begin
      step(1'b1, 4'hF, hold == 0, rnd_data());
      if (wput) hold = 2; else if (hold > 0) hold--;
    end
    chk("t3_count", gnt_log.size() >= 6, 1);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      chk("t3_order", gnt_log[i], (start + i) % NR);

    // Back-pressure.
    repeat (3) step(1'b1, 4'h0, 1'b1, rnd_data());
    c0 = n_wput;
    repeat (20) step(1'b1, 4'hF, 1'b0, rnd_data());
    chk("t4_none", n_wput - c0, 0);
    exp_id = (m_last + 1) % NR;
    step(1'b1, 4'hF, 1'b1, rnd_data());
    chk("t4_put", wput, 1);
    chk("t4_next", gnt_id, exp_id);

    // Enable dropped during PUT.
    repeat (3) step(1'b1, 4'h0, 1'b1, rnd_data());
    c0 = n_wput;
    step(1'b1, 4'hF, 1'b1, rnd_data());
    repeat (6) step(1'b0, 4'hF, 1'b1, rnd_data());
    chk("t5_one_put", n_wput - c0, 1);
    exp_id = (m_last + 1) % NR;
    step(1'b1, 4'hF, 1'b1, rnd_data());
    chk("t5_resume", gnt_id, exp_id);

    // Random traffic.
    repeat (300)
      step($urandom_range(0, 7) != 0, NR'($urandom), $urandom_range(0, 2) != 0, rnd_data());
    chk("wput_eq_ack", n_wput, n_ack);

    // Reset in the middle of PUT.
    repeat (3) step(1'b1, 4'h0, 1'b1, rnd_data());
    arb_en = 1'b1; req = 4'hF; wrdy = 1'b1;
    @(posedge clk); #2;
    chk("t6_put", wput, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_wput_async", wput, 0);
    chk("t6_ack_async", ack, 0);
    chk("t6_busy_async", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 4'b1001, 1'b1, rnd_data());
    chk("t6_first", gnt_id, 0);
    chk("t6_first_put", wput, 1);
    repeat (4) step(1'b1, 4'b1001, 1'b1, rnd_data());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
